// File: rtl/systolic_pkg.sv
// Shared types and helpers for the output-stationary systolic array.
// Holds the controller state encoding and the product extension function.
package systolic_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCompute,
    StFlush,
    StDrain
  } state_e;

  // Widest product the extension helper handles; callers narrow the result.
  localparam int unsigned ExtW = 128;

  // Sign- or zero-extend the low prod_w bits of prod to ExtW bits.
  function automatic logic [ExtW-1:0] ext_prod(input logic [ExtW-1:0] prod,
                                               input int unsigned prod_w,
                                               input logic is_signed);
    logic [ExtW-1:0] mask;
    logic            sign_bit;
    mask     = (ExtW'(1) << prod_w) - ExtW'(1);
    sign_bit = |(prod & (ExtW'(1) << (prod_w - 1)));
    return (prod & mask) | ((is_signed && sign_bit) ? ~mask : '0);
  endfunction

endpackage

// File: rtl/systolic_os_array_pe.sv
// Single output-stationary PE: registered a/b pass-through plus a MAC register.
// The first tag restarts the accumulator so no clear cycle is needed between jobs.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned SIGNED = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] a_west,
  input  logic              a_valid_west,
  input  logic              first_west,
  input  logic [DATA_W-1:0] b_north,
  input  logic              b_valid_north,
  output logic [DATA_W-1:0] a_east,
  output logic              a_valid_east,
  output logic              first_east,
  output logic [DATA_W-1:0] b_south,
  output logic              b_valid_south,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    prod_acc;
  logic                is_signed;

  assign is_signed = (SIGNED != 0);

  // Operands are pre-extended to 2*DATA_W so one unsigned multiply serves both modes.
  always_comb begin
    a_ext    = {{DATA_W{is_signed & a_west[DATA_W-1]}}, a_west};
    b_ext    = {{DATA_W{is_signed & b_north[DATA_W-1]}}, b_north};
    prod     = a_ext * b_ext;
    prod_acc = ACC_W'(ext_prod(ExtW'(prod), 2 * DATA_W, is_signed));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_east        <= '0;
      a_valid_east  <= 1'b0;
      first_east    <= 1'b0;
      b_south       <= '0;
      b_valid_south <= 1'b0;
      acc           <= '0;
    end else begin
      a_east        <= a_west;
      a_valid_east  <= a_valid_west;
      first_east    <= first_west;
      b_south       <= b_north;
      b_valid_south <= b_valid_north;
      if (a_valid_west && b_valid_north) begin
        acc <= first_west ? prod_acc : acc + prod_acc;
      end
    end
  end

endmodule

// File: rtl/systolic_os_array.sv
// Output-stationary ROWS x COLS matrix-multiply engine with built-in input skew,
// first/last job tagging and a row-per-cycle valid/ready result drain.
module systolic_os_array
  import systolic_pkg::*;
#(
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned SIGNED = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ROWS*DATA_W-1:0] a_in,
  input  logic [COLS*DATA_W-1:0] b_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   k_last,
  output logic [COLS*ACC_W-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int unsigned FlushW = $clog2(ROWS + COLS);
  localparam int unsigned DrainW = $clog2(ROWS);
  localparam int unsigned ALaneW = DATA_W + 2;
  localparam int unsigned BLaneW = DATA_W + 1;

  state_e              state_q, state_d;
  logic [FlushW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [DrainW-1:0]   row_q, row_d;
  logic                accept;

  assign in_ready  = (state_q == StIdle) || (state_q == StCompute);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDrain);
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    row_d       = row_q;
    unique case (state_q)
      StIdle, StCompute: begin
        if (accept) begin
          if (k_last) begin
            state_d     = StFlush;
            flush_cnt_d = '0;
          end else begin
            state_d = StCompute;
          end
        end
      end
      StFlush: begin
        // Wait until the last beat has crossed the skew and reached the far corner PE.
        if (flush_cnt_q == FlushW'(ROWS + COLS - 2)) begin
          state_d = StDrain;
          row_d   = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (out_ready) begin
          if (row_q == DrainW'(ROWS - 1)) begin
            state_d = StIdle;
            row_d   = '0;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      flush_cnt_q <= '0;
      row_q       <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      row_q       <= row_d;
    end
  end

  // Common input register shared by every skew lane.
  logic [ROWS*DATA_W-1:0] a_in_q;
  logic [COLS*DATA_W-1:0] b_in_q;
  logic                   in_valid_q;
  logic                   in_first_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_in_q     <= '0;
      b_in_q     <= '0;
      in_valid_q <= 1'b0;
      in_first_q <= 1'b0;
    end else begin
      a_in_q     <= a_in;
      b_in_q     <= b_in;
      in_valid_q <= accept;
      in_first_q <= accept && (state_q == StIdle);
    end
  end

  logic [DATA_W-1:0] a_grid   [ROWS][COLS+1];
  logic              av_grid  [ROWS][COLS+1];
  logic              fst_grid [ROWS][COLS+1];
  logic [DATA_W-1:0] b_grid   [ROWS+1][COLS];
  logic              bv_grid  [ROWS+1][COLS];
  logic [ACC_W-1:0]  acc_grid [ROWS][COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_row_skew
    logic [ALaneW-1:0] lane_in;
    logic [ALaneW-1:0] lane_out;

    assign lane_in = {in_first_q, in_valid_q, a_in_q[r*DATA_W +: DATA_W]};

    if (r == 0) begin : g_direct
      assign lane_out = lane_in;
    end else begin : g_dly
      logic [ALaneW-1:0] sh_q [r];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < r; i++) sh_q[i] <= '0;
        end else begin
          sh_q[0] <= lane_in;
          for (int i = 1; i < r; i++) sh_q[i] <= sh_q[i-1];
        end
      end
      assign lane_out = sh_q[r-1];
    end

    assign a_grid[r][0]   = lane_out[DATA_W-1:0];
    assign av_grid[r][0]  = lane_out[DATA_W];
    assign fst_grid[r][0] = lane_out[DATA_W+1];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col_skew
    logic [BLaneW-1:0] lane_in;
    logic [BLaneW-1:0] lane_out;

    assign lane_in = {in_valid_q, b_in_q[c*DATA_W +: DATA_W]};

    if (c == 0) begin : g_direct
      assign lane_out = lane_in;
    end else begin : g_dly
      logic [BLaneW-1:0] sh_q [c];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < c; i++) sh_q[i] <= '0;
        end else begin
          sh_q[0] <= lane_in;
          for (int i = 1; i < c; i++) sh_q[i] <= sh_q[i-1];
        end
      end
      assign lane_out = sh_q[c-1];
    end

    assign b_grid[0][c]  = lane_out[DATA_W-1:0];
    assign bv_grid[0][c] = lane_out[DATA_W];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe_col
      systolic_pe #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W),
        .SIGNED(SIGNED)
      ) u_pe (
        .clk          (clk),
        .reset        (reset),
        .a_west       (a_grid[r][c]),
        .a_valid_west (av_grid[r][c]),
        .first_west   (fst_grid[r][c]),
        .b_north      (b_grid[r][c]),
        .b_valid_north(bv_grid[r][c]),
        .a_east       (a_grid[r][c+1]),
        .a_valid_east (av_grid[r][c+1]),
        .first_east   (fst_grid[r][c+1]),
        .b_south      (b_grid[r+1][c]),
        .b_valid_south(bv_grid[r+1][c]),
        .acc          (acc_grid[r][c])
      );
    end
  end

  // Drain mux; accumulators are zero after reset so this also reads zero then.
  always_comb begin
    out_data = '0;
    for (int c = 0; c < COLS; c++) begin
      out_data[c*ACC_W +: ACC_W] = acc_grid[row_q][c];
    end
  end

endmodule

// File: tb/tb_systolic_os_array.sv
// Directed job table for the systolic array: a 4x4 unsigned, a 4x4 signed and a
// 2x3 wide-operand instance, plus hand-written reset and stall sequences.
module tb_systolic_os_array;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0]  a_u, b_u;
  logic         iv_u, kl_u, or_u, ov_u, ir_u, busy_u;
  logic [127:0] od_u;
  logic [31:0]  a_s, b_s;
  logic         iv_s, kl_s, or_s, ov_s, ir_s, busy_s;
  logic [127:0] od_s;
  logic [31:0]  a_t;
  logic [47:0]  b_t;
  logic         iv_t, kl_t, or_t, ov_t, ir_t, busy_t;
  logic [119:0] od_t;

  systolic_os_array #(.ROWS(4), .COLS(4), .DATA_W(8), .ACC_W(32), .SIGNED(0)) dut_u (
    .clk(clk), .reset(rst), .a_in(a_u), .b_in(b_u), .in_valid(iv_u), .in_ready(ir_u),
    .k_last(kl_u), .out_data(od_u), .out_valid(ov_u), .out_ready(or_u), .busy(busy_u)
  );

  systolic_os_array #(.ROWS(4), .COLS(4), .DATA_W(8), .ACC_W(32), .SIGNED(1)) dut_s (
    .clk(clk), .reset(rst), .a_in(a_s), .b_in(b_s), .in_valid(iv_s), .in_ready(ir_s),
    .k_last(kl_s), .out_data(od_s), .out_valid(ov_s), .out_ready(or_s), .busy(busy_s)
  );

  systolic_os_array #(.ROWS(2), .COLS(3), .DATA_W(16), .ACC_W(40), .SIGNED(0)) dut_t (
    .clk(clk), .reset(rst), .a_in(a_t), .b_in(b_t), .in_valid(iv_t), .in_ready(ir_t),
    .k_last(kl_t), .out_data(od_t), .out_valid(ov_t), .out_ready(or_t), .busy(busy_t)
  );

  typedef struct {
    int           sel;
    int           nbeats;
    logic [63:0]  a [4];
    logic [63:0]  b [4];
    logic [127:0] row [4];
    int           lat;
    int           nrows;
    bit           bubbles;
    int           stall_row;
    string        name;
  } job_t;

  job_t jobs [8];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic [63:0] a, input logic [63:0] b,
                       input logic v, input logic k);
    case (sel)
      0:       begin a_u = a[31:0]; b_u = b[31:0]; iv_u = v; kl_u = k; end
      1:       begin a_s = a[31:0]; b_s = b[31:0]; iv_s = v; kl_s = k; end
      default: begin a_t = a[31:0]; b_t = b[47:0]; iv_t = v; kl_t = k; end
    endcase
  endtask

  task automatic set_ready(input int sel, input logic v);
    case (sel)
      0:       or_u = v;
      1:       or_s = v;
      default: or_t = v;
    endcase
  endtask

  function automatic logic [127:0] get_od(input int sel);
    case (sel)
      0:       return od_u;
      1:       return od_s;
      default: return {8'h00, od_t};
    endcase
  endfunction

  function automatic logic [127:0] get_ov(input int sel);
    case (sel)
      0:       return 128'(ov_u);
      1:       return 128'(ov_s);
      default: return 128'(ov_t);
    endcase
  endfunction

  function automatic logic [127:0] get_ir(input int sel);
    case (sel)
      0:       return 128'(ir_u);
      1:       return 128'(ir_s);
      default: return 128'(ir_t);
    endcase
  endfunction

  function automatic logic [127:0] get_busy(input int sel);
    case (sel)
      0:       return 128'(busy_u);
      1:       return 128'(busy_s);
      default: return 128'(busy_t);
    endcase
  endfunction

  task automatic set_job(input int j, input int sel, input int nb, input int lat,
                         input int nrows, input bit bub, input int stall, input string name);
    jobs[j].sel       = sel;
    jobs[j].nbeats    = nb;
    jobs[j].lat       = lat;
    jobs[j].nrows     = nrows;
    jobs[j].bubbles   = bub;
    jobs[j].stall_row = stall;
    jobs[j].name      = name;
  endtask

  task automatic run_job(input int j);
    job_t jb;
    int   lat;
    jb = jobs[j];
    for (int k = 0; k < jb.nbeats; k++) begin
      @(negedge clk);
      if (k == 0) check($sformatf("%s in_ready idle", jb.name), get_ir(jb.sel), 128'd1);
      drive(jb.sel, jb.a[k], jb.b[k], 1'b1, k == jb.nbeats - 1);
      if (jb.bubbles && k != jb.nbeats - 1) begin
        @(negedge clk);
        // Bubble with junk data and a stray k_last that must be ignored.
        drive(jb.sel, {64{1'b1}}, {64{1'b1}}, 1'b0, 1'b1);
      end
    end
    @(negedge clk);
    drive(jb.sel, '0, '0, 1'b0, 1'b0);
    check($sformatf("%s busy flush", jb.name), get_busy(jb.sel), 128'd1);
    check($sformatf("%s in_ready flush", jb.name), get_ir(jb.sel), 128'd0);
    lat = 0;
    while (get_ov(jb.sel) == 128'd0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("%s latency", jb.name), 128'(lat), 128'(jb.lat));
    for (int r = 0; r < jb.nrows; r++) begin
      check($sformatf("%s out_valid row%0d", jb.name, r), get_ov(jb.sel), 128'd1);
      check($sformatf("%s data row%0d", jb.name, r), get_od(jb.sel), jb.row[r]);
      if (r == jb.stall_row) begin
        set_ready(jb.sel, 1'b0);
        drive(jb.sel, {64{1'b1}}, {64{1'b1}}, 1'b1, 1'b0);
        repeat (3) begin
          @(negedge clk);
          check($sformatf("%s stall valid row%0d", jb.name, r), get_ov(jb.sel), 128'd1);
          check($sformatf("%s stall data row%0d", jb.name, r), get_od(jb.sel), jb.row[r]);
          check($sformatf("%s stall in_ready", jb.name), get_ir(jb.sel), 128'd0);
        end
        set_ready(jb.sel, 1'b1);
        drive(jb.sel, '0, '0, 1'b0, 1'b0);
      end
      @(negedge clk);
    end
    check($sformatf("%s out_valid after", jb.name), get_ov(jb.sel), 128'd0);
    check($sformatf("%s in_ready after", jb.name), get_ir(jb.sel), 128'd1);
    check($sformatf("%s busy after", jb.name), get_busy(jb.sel), 128'd0);
  endtask

  initial begin
    logic [39:0] s;

    // 4x4 unsigned, A = I, B = 1..16 row-major.
    set_job(0, 0, 4, 7, 4, 1'b0, -1, "ident");
    jobs[0].a   = '{64'h00000001, 64'h00000100, 64'h00010000, 64'h01000000};
    jobs[0].b   = '{64'h04030201, 64'h08070605, 64'h0C0B0A09, 64'h100F0E0D};
    jobs[0].row = '{128'h00000004_00000003_00000002_00000001,
                    128'h00000008_00000007_00000006_00000005,
                    128'h0000000C_0000000B_0000000A_00000009,
                    128'h00000010_0000000F_0000000E_0000000D};
    // Two beats of distinct operands so each PE sees a different sum.
    set_job(1, 0, 2, 7, 4, 1'b0, -1, "mixed");
    jobs[1].a   = '{64'h04030201, 64'h03010002, 64'h0, 64'h0};
    jobs[1].b   = '{64'h08070605, 64'h00020101, 64'h0, 64'h0};
    jobs[1].row = '{128'h00000008_0000000B_00000008_00000007,
                    128'h00000010_0000000E_0000000C_0000000A,
                    128'h00000018_00000017_00000013_00000010,
                    128'h00000020_00000022_0000001B_00000017};
    set_job(2, 0, 4, 7, 4, 1'b0, -1, "umax");
    jobs[2].a   = '{64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF};
    jobs[2].b   = jobs[2].a;
    jobs[2].row = '{{4{32'h0003F804}}, {4{32'h0003F804}}, {4{32'h0003F804}}, {4{32'h0003F804}}};
    set_job(3, 0, 4, 7, 4, 1'b1, 2, "ident_bubble");
    jobs[3].a   = jobs[0].a;
    jobs[3].b   = jobs[0].b;
    jobs[3].row = jobs[0].row;
    set_job(4, 0, 4, 7, 4, 1'b0, -1, "ones");
    jobs[4].a   = '{64'h01010101, 64'h01010101, 64'h01010101, 64'h01010101};
    jobs[4].b   = jobs[4].a;
    jobs[4].row = '{{4{32'h4}}, {4{32'h4}}, {4{32'h4}}, {4{32'h4}}};
    set_job(5, 0, 1, 7, 4, 1'b0, -1, "one_beat");
    jobs[5].a   = '{64'h02020202, 64'h0, 64'h0, 64'h0};
    jobs[5].b   = '{64'h03030303, 64'h0, 64'h0, 64'h0};
    jobs[5].row = '{{4{32'h6}}, {4{32'h6}}, {4{32'h6}}, {4{32'h6}}};
    set_job(6, 1, 3, 7, 4, 1'b0, -1, "signed");
    jobs[6].a   = '{64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h0};
    jobs[6].b   = '{64'h7F7F7F7F, 64'h7F7F7F7F, 64'h7F7F7F7F, 64'h0};
    jobs[6].row = '{{4{32'hFFFFFE83}}, {4{32'hFFFFFE83}}, {4{32'hFFFFFE83}}, {4{32'hFFFFFE83}}};
    set_job(7, 2, 3, 4, 2, 1'b0, -1, "r2c3");
    jobs[7].a   = '{{32'h0, 16'h1234, 16'hFFFF}, {32'h0, 16'hABCD, 16'h0003},
                    {32'h0, 16'h0001, 16'hFFFF}, 64'h0};
    jobs[7].b   = '{{16'h0, 16'h8000, 16'h0002, 16'hFFFF}, {16'h0, 16'h0001, 16'hFFFF, 16'h0010},
                    {16'h0, 16'h0100, 16'h7FFF, 16'hFFFF}, 64'h0};
    jobs[7].row = '{128'h0, 128'h0, 128'h0, 128'h0};
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        s = '0;
        for (int k = 0; k < 3; k++) begin
          s = s + 40'(jobs[7].a[k][r*16 +: 16]) * 40'(jobs[7].b[k][c*16 +: 16]);
        end
        jobs[7].row[r][c*40 +: 40] = s;
      end
    end

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(i, '0, '0, 1'b0, 1'b0);
      set_ready(i, 1'b1);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset in_ready dut%0d", i), get_ir(i), 128'd1);
      check($sformatf("reset out_valid dut%0d", i), get_ov(i), 128'd0);
      check($sformatf("reset busy dut%0d", i), get_busy(i), 128'd0);
      check($sformatf("reset out_data dut%0d", i), get_od(i), 128'd0);
    end
    rst = 1'b0;

    for (int j = 0; j < 8; j++) run_job(j);

    // Reset in the middle of FLUSH, then a clean job must still be correct.
    @(negedge clk);
    drive(0, jobs[0].a[0], jobs[0].b[0], 1'b1, 1'b0);
    @(negedge clk);
    drive(0, jobs[0].a[1], jobs[0].b[1], 1'b1, 1'b1);
    @(negedge clk);
    drive(0, '0, '0, 1'b0, 1'b0);
    check("midreset busy before", get_busy(0), 128'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset out_valid", get_ov(0), 128'd0);
    check("midreset busy", get_busy(0), 128'd0);
    check("midreset in_ready", get_ir(0), 128'd1);
    check("midreset out_data", get_od(0), 128'd0);
    rst = 1'b0;
    run_job(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_os_array.md
# systolic_os_array

Parametrised output-stationary systolic matrix-multiply engine, the generalised successor of the fixed 4x4 MAC grid. It computes C = A·B for a ROWS×K by K×COLS product. One beat per cycle supplies one column of A and one row of B. The block performs the diagonal input skewing itself, supports signed and unsigned operands, marks job boundaries with a first/last tag, and drains results one row per cycle over a valid/ready handshake.

## Interface
- ROWS, 4, number of PE rows (≥2)
- COLS, 4, number of PE columns (≥2)
- DATA_W, 8, operand width
- ACC_W, 32, accumulator width; must be ≥ 2·DATA_W
- SIGNED, 0, 1 = two's-complement operands, 0 = unsigned
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- a_in  in  ROWS·DATA_W  element k of each A row; row r is at bits [r·DATA_W +: DATA_W]
- b_in  in  COLS·DATA_W  element k of each B column; column c is at bits [c·DATA_W +: DATA_W]
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid & in_ready
- k_last  in  1  qualifies the accepted beat as the final K beat of the job
- out_data  out  COLS·ACC_W  one result row of C; column c is at bits [c·ACC_W +: ACC_W]
- out_valid  out  1  out_data holds a result row
- out_ready  in  1  consumer accepts the row
- busy  out  1  job in progress

## Operation
- FSM states are IDLE, COMPUTE, FLUSH and DRAIN.
- in_ready = 1 in IDLE and COMPUTE, 0 otherwise. busy = 1 when the state is not IDLE.
- IDLE: the first accepted beat moves the FSM to COMPUTE. That beat carries first=1 through the pipeline.
- COMPUTE: each accepted beat enters the skew network. Cycles without an accepted beat are bubbles: valid=0 and no accumulation.
- Any state: an accepted beat with k_last=1 moves the FSM to FLUSH, including the IDLE case of a one-beat job. k_last without in_valid is ignored.
- Skew: all inputs pass through one input register. Row r then passes through r further delay registers, and column c through c further registers.
- Movement: a moves right one PE per cycle and b moves down one PE per cycle. Valid and first bits travel with a.
- PE(r,c) accumulates when both of its operand valids are high:
  - first=1: acc ← ext(prod)
  - first=0: acc ← acc + ext(prod)
- The first tag is what clears stale results between jobs. There is no separate clear cycle.
- Arithmetic: prod is 2·DATA_W bits, signed or unsigned per SIGNED. It is sign- or zero-extended to ACC_W. Addition wraps modulo 2^ACC_W with no saturation and no overflow flag.
- FLUSH: a counter runs for ROWS+COLS-1 cycles, then the FSM moves to DRAIN with the row index d=0.
- DRAIN: out_valid = 1 and out_data = acc row d. On out_valid & out_ready, d increments. The handshake on d = ROWS-1 returns the FSM to IDLE.
- Accumulators hold throughout FLUSH end, DRAIN and IDLE until the next job's first beat arrives.
- Reset, including mid-job, forces:
  - FSM to IDLE, counters and d to 0
  - all pipeline valid/first bits to 0
  - all accumulators to 0
- Output values during and after reset: in_ready=1, out_valid=0, busy=0, out_data=0.

## Timing
- The accept edge E0 is the edge on which the beat is registered.
- PE(r,c) updates with beat k's product on edge E0+1+r+c.
- If k_last is accepted at E0:
  - the last PE update is at E0+ROWS+COLS-1
  - DRAIN is entered on the same edge
  - out_valid is high in the following cycle (7 cycles after E0 for 4×4)
- With out_ready held high, DRAIN takes ROWS cycles, and in_ready returns 1 the cycle after the last row handshake.
- out_data and out_valid are stable while out_valid & !out_ready.
- in_ready depends only on state, never on in_valid. out_valid depends only on state.
- Throughput: one K-beat per cycle. Job overhead is ROWS+COLS-1+ROWS cycles.

## Structure
- Package systolic_pkg holds the state enum type and an ext_prod(prod, SIGNED) sign/zero-extend function.
- Sub-module systolic_pe is a single PE. It has:
  - registered a/b pass-through
  - valid and first pass-through
  - multiply-accumulate register
  - parameters DATA_W, ACC_W, SIGNED
- The top level contains the FSM, the skew delay lines, the PE generate grid and the drain row mux.

## Test plan
- 4×4 unsigned, A=I, B=[1..16] row-major, 4 beats, out_ready=1 → rows out 1..4, 5..8, 9..12, 13..16; out_valid rises 7 cycles after the k_last accept.
- SIGNED=1, a=0xFF (−1), b=0x7F for 3 beats → every element is 0xFFFFFE83 (−381); unsigned build with a=b=0xFF, 4 beats → 0x0003F804.
- First test with bubbles between every beat, plus out_ready low for 3 cycles on row 2 → identical results, and row 2 data stable while stalled.
- Back-to-back jobs: an all-ones 4-beat job (result 4) followed by a one-beat job with a=2, b=3 → second drain shows 6 everywhere, with no residue from the first job.
- Reset asserted mid-FLUSH → next cycle out_valid=0, busy=0, in_ready=1; a following first-test job produces correct results.
- ROWS=2, COLS=3, DATA_W=16, ACC_W=40 → out_valid 4 cycles after the k_last accept, drain lasts 2 handshakes, and values match a reference model.
